lsu_ram_master: RTL and testbench

- Initiator side of the single-port word RAM interface: `ce`, 4-bit byte write enable, word address, 32-bit write data, and a combinational 32-bit read return.
- Accepts RV32I load/store requests from the CPU memory stage and converts byte addresses into RAM strobes and byte-lane positioning.
- Splits misaligned accesses that cross a word boundary into two consecutive RAM accesses.
- Sign- or zero-extends load data and returns a one-cycle response.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_ram_master_lane_align.sv | 54 +++++
 rtl/lsu_ram_master.sv | 153 +++++++++++++++
 tb/tb_lsu_ram_master.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU-to-RAM initiator.
// Holds the funct3 codes, the FSM state encoding and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Only the low two funct3 bits select the width; the top bit is signedness.
  function automatic logic [2:0] size_bytes(input logic [1:0] f3_lo);
    case (f3_lo)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ram_master_lane_align.sv
// Combinational byte-lane logic: strobe masks, store data placement across
// two words, and extraction plus extension of load data.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo_word,
  input  logic [31:0] i_hi_word,
  output logic [3:0]  o_lo_mask,
  output logic [3:0]  o_hi_mask,
  output logic        o_split,
  output logic [63:0] o_wd64,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_base;
  logic [7:0]  w_mask8;
  logic [31:0] w_hi;
  logic [63:0] w_cat;
  logic [31:0] w_sh;

  always_comb begin
    case (size_bytes(i_funct3[1:0]))
      3'd1:    w_base = 8'h01;
      3'd2:    w_base = 8'h03;
      default: w_base = 8'h0F;
    endcase
  end

  assign w_mask8   = w_base << i_off;
  assign o_lo_mask = w_mask8[3:0];
  assign o_hi_mask = w_mask8[7:4];
  assign o_split   = (w_mask8[7:4] != 4'd0);
  assign o_wd64    = {32'd0, i_wdata} << {i_off, 3'b000};

  // A stale high word must not leak into a non-crossing load.
  assign w_hi  = o_split ? i_hi_word : 32'd0;
  assign w_cat = {w_hi, i_lo_word};
  assign w_sh  = 32'(w_cat >> {i_off, 3'b000});

  always_comb begin
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_H:    o_rdata = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_W:    o_rdata = w_sh;
      F3_BU:   o_rdata = {24'd0, w_sh[7:0]};
      F3_HU:   o_rdata = {16'd0, w_sh[15:0]};
      default: o_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_ram_master.sv
// RV32I load/store front end for a single-port word RAM. Misaligned accesses
// that cross a word boundary are split into two back-to-back RAM cycles.
module lsu_ram_master
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [31:0]           i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_ram_ce,
  output logic [3:0]            o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [31:0]           o_ram_din,
  input  logic [31:0]           i_ram_dout
);

  localparam logic [ADDR_WIDTH-1:0] WIDX_ONE = ADDR_WIDTH'(1);

  lsu_state_t            r_state;
  logic                  r_we;
  logic                  r_err;
  logic [2:0]            r_funct3;
  logic [1:0]            r_off;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [31:0]           r_wdata;
  logic [31:0]           r_lo_word;
  logic [31:0]           r_hi_word;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [31:0]           r_rsp_rdata;

  logic                  w_accept;
  logic                  w_req_err;
  logic [3:0]            w_lo_mask;
  logic [3:0]            w_hi_mask;
  logic                  w_split;
  logic [63:0]           w_wd64;
  logic [31:0]           w_rdata;

  assign o_req_ready = (r_state == IDLE) && !i_rst;
  assign w_accept    = i_req_valid && o_req_ready;

  always_comb begin
    w_req_err = 1'b0;
    if ((i_req_addr >> (ADDR_WIDTH + 2)) != 32'd0) w_req_err = 1'b1;
    if (i_req_we) begin
      if (i_req_funct3 > 3'd2) w_req_err = 1'b1;
    end else if (i_req_funct3 == 3'd3 || i_req_funct3 == 3'd6 || i_req_funct3 == 3'd7) begin
      w_req_err = 1'b1;
    end
  end

  lsu_lane_align u_align (
    .i_off     (r_off),
    .i_funct3  (r_funct3),
    .i_wdata   (r_wdata),
    .i_lo_word (r_lo_word),
    .i_hi_word (r_hi_word),
    .o_lo_mask (w_lo_mask),
    .o_hi_mask (w_hi_mask),
    .o_split   (w_split),
    .o_wd64    (w_wd64),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_widx      <= '0;
      r_wdata     <= 32'd0;
      r_lo_word   <= 32'd0;
      r_hi_word   <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we     <= i_req_we;
            r_err    <= w_req_err;
            r_funct3 <= i_req_funct3;
            r_off    <= i_req_addr[1:0];
            r_widx   <= i_req_addr[ADDR_WIDTH+1:2];
            r_wdata  <= i_req_wdata;
            r_state  <= w_req_err ? RESP : ACC1;
          end
        end
        ACC1: begin
          r_lo_word <= i_ram_dout;
          r_state   <= w_split ? ACC2 : RESP;
        end
        ACC2: begin
          r_hi_word <= i_ram_dout;
          r_state   <= RESP;
        end
        RESP: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_err;
          r_rsp_rdata <= (r_err || r_we) ? 32'd0 : w_rdata;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset gates the strobes directly so an in-flight write cannot land on a reset edge.
  always_comb begin
    o_ram_ce   = 1'b0;
    o_ram_we   = 4'd0;
    o_ram_addr = '0;
    o_ram_din  = 32'd0;
    if (!i_rst) begin
      case (r_state)
        ACC1: begin
          o_ram_ce   = 1'b1;
          o_ram_addr = r_widx;
          o_ram_we   = r_we ? w_lo_mask : 4'd0;
          o_ram_din  = w_wd64[31:0];
        end
        ACC2: begin
          o_ram_ce   = 1'b1;
          o_ram_addr = r_widx + WIDX_ONE;
          o_ram_we   = r_we ? w_hi_mask : 4'd0;
          o_ram_din  = w_wd64[63:32];
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Randomized self-checking bench for lsu_ram_master against a byte-addressed
// memory model, plus directed cases for alignment, splitting, errors, wrap and reset.
module tb_lsu_ram_master;

  localparam int AW        = 16;
  localparam int NBYTES    = 1 << (AW + 2);
  localparam int BYTE_MASK = NBYTES - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqValid;
  logic          reqReady;
  logic          reqWe;
  logic [2:0]    reqFunct3;
  logic [31:0]   reqAddr;
  logic [31:0]   reqWdata;
  logic          rspValid;
  logic [31:0]   rspRdata;
  logic          rspErr;
  logic          ramCe;
  logic [3:0]    ramWe;
  logic [AW-1:0] ramAddr;
  logic [31:0]   ramDin;
  logic [31:0]   ramDout;

  int nCmp  = 0;
  int nFail = 0;
  int weNoCe = 0;

  always #5 clk = ~clk;

  lsu_ram_master #(.ADDR_WIDTH(AW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (reqValid),
    .o_req_ready  (reqReady),
    .i_req_we     (reqWe),
    .i_req_funct3 (reqFunct3),
    .i_req_addr   (reqAddr),
    .i_req_wdata  (reqWdata),
    .o_rsp_valid  (rspValid),
    .o_rsp_rdata  (rspRdata),
    .o_rsp_err    (rspErr),
    .o_ram_ce     (ramCe),
    .o_ram_we     (ramWe),
    .o_ram_addr   (ramAddr),
    .o_ram_din    (ramDin),
    .i_ram_dout   (ramDout)
  );

  // Behavioural single-port RAM with combinational read.
  logic [31:0] mem [0:(1<<AW)-1];
  logic [7:0]  refMem [0:NBYTES-1];

  assign ramDout = mem[ramAddr];

  always @(posedge clk) begin
    if (ramCe)
      for (int b = 0; b < 4; b++)
        if (ramWe[b]) mem[ramAddr][8*b +: 8] <= ramDin[8*b +: 8];
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    we;
    logic [31:0]   din;
  } acc_t;

  acc_t accQ[$];

  always @(negedge clk) begin
    if (ramCe) accQ.push_back(acc_t'({ramAddr, ramWe, ramDin}));
    else if (ramWe != 4'd0) weNoCe++;
  end

  // Reference model, working on byte addresses.
  function automatic int sizeOf(logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic expErr(logic we, logic [2:0] f3, logic [31:0] addr);
    if (addr >= 32'(NBYTES)) return 1'b1;
    if (we) return (f3 > 3'd2);
    return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
  endfunction

  function automatic int expLat(logic err, logic [2:0] f3, logic [31:0] addr);
    if (err) return 1;
    if (int'(addr[1:0]) + sizeOf(f3) > 4) return 3;
    return 2;
  endfunction

  function automatic logic [31:0] expLoad(logic [2:0] f3, logic [31:0] addr);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < sizeOf(f3); i++) v[8*i +: 8] = refMem[(int'(addr) + i) & BYTE_MASK];
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd2:    return v;
      3'd4:    return {24'd0, v[7:0]};
      3'd5:    return {16'd0, v[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void modelStore(logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata);
    for (int i = 0; i < sizeOf(f3); i++) refMem[(int'(addr) + i) & BYTE_MASK] = wdata[8*i +: 8];
  endfunction

  function automatic int memDiffs(logic [31:0] addr);
    int d, b;
    d = 0;
    for (int i = -4; i < 8; i++) begin
      b = (int'(addr) + i) & BYTE_MASK;
      if (mem[b >> 2][8*(b & 3) +: 8] !== refMem[b]) d++;
    end
    return d;
  endfunction

  // Issues one request, scrambles req_* after acceptance and waits for the response.
  task automatic doReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
    int guard;
    rdata = 32'd0;
    err   = 1'b0;
    lat   = 0;
    @(negedge clk);
    reqValid = 1'b1; reqWe = we; reqFunct3 = f3; reqAddr = addr; reqWdata = wdata;
    guard = 0;
    while (!reqReady && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    accQ.delete();
    @(posedge clk);
    #1;
    reqValid  = 1'b0;
    reqWe     = 1'($urandom);
    reqFunct3 = 3'($urandom);
    reqAddr   = $urandom;
    reqWdata  = $urandom;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (rspValid) begin
        lat   = k;
        rdata = rspRdata;
        err   = rspErr;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nCmp++;
    if (reqReady !== 1'b0) begin
      nFail++; $display("[TB] FAIL reset_ready_low: got %b expected 0", reqReady);
    end
    nCmp++;
    if ({ramCe, ramWe, ramAddr, ramDin} !== '0) begin
      nFail++; $display("[TB] FAIL reset_ram_idle: got ce=%b we=%h addr=%h din=%h expected all 0", ramCe, ramWe, ramAddr, ramDin);
    end
    rst = 1'b0;
    #1;
    nCmp++;
    if ({rspValid, rspErr, rspRdata} !== '0) begin
      nFail++; $display("[TB] FAIL reset_rsp: got valid=%b err=%b rdata=%h expected 0/0/0", rspValid, rspErr, rspRdata);
    end
    nCmp++;
    if (reqReady !== 1'b1) begin
      nFail++; $display("[TB] FAIL reset_ready_after: got %b expected 1", reqReady);
    end
  endtask

  task automatic test_sw_aligned();
    logic [31:0] rd; logic er; int lat;
    doReq(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
    modelStore(3'd2, 32'h10, 32'hDEADBEEF);
    nCmp++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
      nFail++; $display("[TB] FAIL sw_rsp: got lat=%0d err=%b rdata=%h expected 2/0/0", lat, er, rd);
    end
    nCmp++;
    if (accQ.size() != 1 || accQ[0] !== acc_t'({16'd4, 4'hF, 32'hDEADBEEF})) begin
      nFail++; $display("[TB] FAIL sw_access: got n=%0d first=%h expected 1 access 0004_f_deadbeef", accQ.size(), (accQ.size() > 0) ? accQ[0] : acc_t'(0));
    end
    nCmp++;
    if (memDiffs(32'h10) != 0) begin
      nFail++; $display("[TB] FAIL sw_mem: got %0d differing bytes expected 0", memDiffs(32'h10));
    end
    @(posedge clk);
    #1;
    nCmp++;
    if (rspValid !== 1'b0) begin
      nFail++; $display("[TB] FAIL sw_pulse: got rsp_valid=%b one cycle later expected 0", rspValid);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    doReq(1'b1, 3'd0, 32'h13, 32'h000000A5, rd, er, lat);
    modelStore(3'd0, 32'h13, 32'h000000A5);
    nCmp++;
    if (accQ.size() != 1 || accQ[0].addr !== 16'd4 || accQ[0].we !== 4'h8 || accQ[0].din[31:24] !== 8'hA5) begin
      nFail++; $display("[TB] FAIL sb_access: got n=%0d first=%h expected addr 4 we 8 din[31:24] a5", accQ.size(), (accQ.size() > 0) ? accQ[0] : acc_t'(0));
    end
    doReq(1'b0, 3'd0, 32'h13, 32'h0, rd, er, lat);
    nCmp++;
    if (rd !== 32'hFFFFFFA5 || er !== 1'b0 || lat !== 2) begin
      nFail++; $display("[TB] FAIL lb_rdata: got %h err=%b lat=%0d expected ffffffa5/0/2", rd, er, lat);
    end
    doReq(1'b0, 3'd4, 32'h13, 32'h0, rd, er, lat);
    nCmp++;
    if (rd !== 32'h000000A5) begin
      nFail++; $display("[TB] FAIL lbu_rdata: got %h expected 000000a5", rd);
    end
  endtask

  task automatic test_split();
    logic [31:0] rd; logic er; int lat;
    doReq(1'b1, 3'd2, 32'h06, 32'h11223344, rd, er, lat);
    modelStore(3'd2, 32'h06, 32'h11223344);
    nCmp++;
    if (accQ.size() != 2 || accQ[0].addr !== 16'd1 || accQ[0].we !== 4'hC || accQ[0].din[31:16] !== 16'h3344
        || accQ[1].addr !== 16'd2 || accQ[1].we !== 4'h3 || accQ[1].din[15:0] !== 16'h1122) begin
      nFail++; $display("[TB] FAIL split_sw_access: got n=%0d a0=%h expected 0001_c_3344xxxx then 0002_3_xxxx1122", accQ.size(), (accQ.size() > 0) ? accQ[0] : acc_t'(0));
    end
    nCmp++;
    if (lat !== 3 || memDiffs(32'h06) != 0) begin
      nFail++; $display("[TB] FAIL split_sw_mem: got lat=%0d diffs=%0d expected 3/0", lat, memDiffs(32'h06));
    end
    doReq(1'b0, 3'd2, 32'h06, 32'h0, rd, er, lat);
    nCmp++;
    if (rd !== 32'h11223344 || lat !== 3) begin
      nFail++; $display("[TB] FAIL split_lw: got %h lat=%0d expected 11223344 lat=3", rd, lat);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic        weT [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  f3T [3] = '{3'd2, 3'd3, 3'd3};
    logic [31:0] adT [3] = '{32'h00040000, 32'h0, 32'h20};
    for (int i = 0; i < 3; i++) begin
      doReq(weT[i], f3T[i], adT[i], $urandom, rd, er, lat);
      nCmp++;
      if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || accQ.size() != 0) begin
        nFail++; $display("[TB] FAIL error_case%0d: got err=%b rdata=%h lat=%0d ce_cycles=%0d expected 1/0/1/0", i, er, rd, lat, accQ.size());
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat; logic [15:0] h;
    h = {refMem[0], refMem[NBYTES-1]};
    doReq(1'b0, 3'd1, 32'h3FFFF, 32'h0, rd, er, lat);
    nCmp++;
    if (accQ.size() != 2 || accQ[1].addr !== 16'd0 || accQ[0].addr !== 16'hFFFF) begin
      nFail++; $display("[TB] FAIL wrap_addr: got n=%0d expected accesses at ffff then 0000", accQ.size());
    end
    nCmp++;
    if (rd !== {{16{h[15]}}, h} || lat !== 3 || er !== 1'b0) begin
      nFail++; $display("[TB] FAIL wrap_lh: got %h lat=%0d expected %h lat=3", rd, lat, {{16{h[15]}}, h});
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd, expRd; logic er, we, expE; logic [2:0] f3; int lat, expL;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'h3FFF0 + $urandom_range(0, 15);
        1:       addr = $urandom | 32'h00040000;
        default: addr = $urandom_range(0, 63);
      endcase
      we = 1'($urandom);
      f3 = 3'($urandom);
      wd = $urandom;
      expE  = expErr(we, f3, addr);
      expL  = expLat(expE, f3, addr);
      expRd = (expE || we) ? 32'd0 : expLoad(f3, addr);
      doReq(we, f3, addr, wd, rd, er, lat);
      if (we && !expE) modelStore(f3, addr, wd);
      nCmp++;
      if (er !== expE || lat !== expL || rd !== expRd || accQ.size() != (expE ? 0 : expL - 1)) begin
        nFail++; $display("[TB] FAIL rand%0d we=%b f3=%0d addr=%h: got err=%b lat=%0d rdata=%h ce=%0d expected %b/%0d/%h/%0d",
                          n, we, f3, addr, er, lat, rd, accQ.size(), expE, expL, expRd, expE ? 0 : expL - 1);
      end
      if (we && !expE) begin
        nCmp++;
        if (memDiffs(addr) != 0) begin
          nFail++; $display("[TB] FAIL rand%0d_mem addr=%h: got %0d differing bytes expected 0", n, addr, memDiffs(addr));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] wd;
    wd = $urandom;
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b1; reqFunct3 = 3'd2; reqAddr = 32'h0A; reqWdata = wd;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(posedge clk);
    #1;
    nCmp++;
    if (ramCe !== 1'b1 || ramAddr !== 16'd3 || ramWe !== 4'h3) begin
      nFail++; $display("[TB] FAIL midrst_acc2: got ce=%b addr=%h we=%h expected 1/0003/3", ramCe, ramAddr, ramWe);
    end
    rst = 1'b1;
    #1;
    nCmp++;
    if (ramCe !== 1'b0 || ramWe !== 4'd0) begin
      nFail++; $display("[TB] FAIL midrst_strobe: got ce=%b we=%h expected 0/0", ramCe, ramWe);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    nCmp++;
    if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
      nFail++; $display("[TB] FAIL midrst_after: got rsp_valid=%b ready=%b expected 0/1", rspValid, reqReady);
    end
    modelStore(3'd1, 32'h0A, wd);
    @(posedge clk);
    #1;
    nCmp++;
    if (rspValid !== 1'b0 || memDiffs(32'h0A) != 0) begin
      nFail++; $display("[TB] FAIL midrst_mem: got rsp_valid=%b diffs=%0d expected 0/0", rspValid, memDiffs(32'h0A));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqFunct3 = 3'd0; reqAddr = 32'd0; reqWdata = 32'd0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = $urandom;
      for (int b = 0; b < 4; b++) refMem[4*i + b] = mem[i][8*b +: 8];
    end
    test_reset();
    test_sw_aligned();
    test_byte();
    test_split();
    test_errors();
    test_wrap();
    test_random();
    test_reset_mid();
    nCmp++;
    if (weNoCe != 0) begin
      nFail++; $display("[TB] FAIL we_without_ce: got %0d cycles expected 0", weNoCe);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
